// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Types and constants shared by the FPU adder arbiter and its sub-modules.
//   fpu_state_t : adder status code that travels with every result
//   fpu_tag_t   : {valid, id} entry of the tag pipeline
//   FP32_*      : single-precision field widths
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_W     = 1 + FP32_EXP_W + FP32_MAN_W;

  // Default requester count; the tag id field is sized from it, so a top
  // instantiated with a different N_REQ must keep ID_W equal to TAG_ID_W.
  localparam int N_REQ_DEF = 4;
  localparam int TAG_ID_W  = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } fpu_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } fpu_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// N-wide round-robin priority picker. The search for a winner starts at the
// pointer and wraps; the pointer moves to one past the winner after a grant.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   i_req     : raw requests
//   i_mask    : per-requester enable (a request only counts when masked in)
//   o_grant   : one-hot grant, or zero when nothing is eligible
//   o_gid     : index of the granted requester (0 when no grant)
//   o_any     : a grant is being given this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_mask,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_gid,
  output logic            o_any
);

  logic [ID_W-1:0] r_ptr;
  logic [N-1:0]    w_elig;
  logic [N-1:0]    w_grant;
  logic [ID_W-1:0] w_gid;
  logic            w_any;

  assign w_elig = i_req & i_mask;

  // Walk the requesters in priority order starting at the pointer; the
  // first eligible one wins.
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_grant = '0;
    w_gid   = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N);
      if (!w_any && w_elig[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gid          = w_idx;
        w_any          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (int'(w_gid) == N - 1) ? '0 : w_gid + ID_W'(1);
    end
  end

  assign o_grant = w_grant;
  assign o_gid   = w_gid;
  assign o_any   = w_any;

endmodule

// File: rtl/fpu_add_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_add_arbiter
// Shares one pipelined floating-point adder among N_REQ requesters. A
// round-robin picker, gated by per-requester credit counters, selects one
// operation per cycle; a tag pipeline as deep as the adder carries the
// requester id alongside the operation and steers the result back.
// No arithmetic is done here.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_vld/req_a/req_b   : per-requester request and operands (packed, i*32)
//   req_rdy               : per-requester grant
//   fpu_a/fpu_b           : registered operands to the adder
//   fpu_arg_vld           : issue strobe to the adder
//   fpu_result/fpu_state  : adder result and status
//   fpu_res_vld           : adder result valid, LATENCY cycles after issue
//   rsp_vld/rsp_id        : response strobe and owning requester
//   rsp_result/rsp_state  : registered copy of the adder result/status
//   busy                  : some requester has an operation in flight
//   err_sync              : sticky flag, adder result and tag disagreed
//
// Handshake: a request transfers in a cycle where req_vld[i] and req_rdy[i]
// are both high; req_rdy[i] depends combinationally on req_vld and is high
// for at most one requester. Responses have no ready: rsp_vld is a one-cycle
// strobe that the requester must take.
// ---------------------------------------------------------------------------
module fpu_add_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int LATENCY = 6,
  parameter int MAX_OUT = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*FP32_W-1:0] req_a,
  input  logic [N_REQ*FP32_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [FP32_W-1:0]       fpu_a,
  output logic [FP32_W-1:0]       fpu_b,
  output logic                    fpu_arg_vld,
  input  logic [FP32_W-1:0]       fpu_result,
  input  logic [1:0]              fpu_state,
  input  logic                    fpu_res_vld,
  output logic                    rsp_vld,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP32_W-1:0]       rsp_result,
  output logic [1:0]              rsp_state,
  output logic                    busy,
  output logic                    err_sync
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [FP32_W-1:0] w_a [N_REQ];
  logic [FP32_W-1:0] w_b [N_REQ];
  logic [N_REQ-1:0]  w_credit_ok;
  logic [N_REQ-1:0]  w_grant;
  logic [N_REQ-1:0]  w_ret;
  logic [ID_W-1:0]   w_gid;
  logic              w_any;
  logic              w_busy;
  logic              w_rsp_take;
  fpu_tag_t          w_tag_out;

  logic [CNT_W-1:0]  r_cnt [N_REQ];
  logic [FP32_W-1:0] r_fpu_a;
  logic [FP32_W-1:0] r_fpu_b;
  fpu_tag_t          r_issue;
  fpu_tag_t          r_tag [LATENCY];
  logic              r_rsp_vld;
  logic [ID_W-1:0]   r_rsp_id;
  logic [FP32_W-1:0] r_rsp_result;
  fpu_state_t        r_rsp_state;
  logic              r_err;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_req
      assign w_a[g]         = req_a[g*FP32_W +: FP32_W];
      assign w_b[g]         = req_b[g*FP32_W +: FP32_W];
      assign w_credit_ok[g] = (r_cnt[g] < CNT_W'(MAX_OUT));
      // A tag leaving the pipeline returns its credit whether or not the
      // adder produced a matching result, so a lost result cannot leak it.
      assign w_ret[g]       = w_tag_out.valid && (w_tag_out.id == TAG_ID_W'(g));
    end
  endgenerate

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_vld),
    .i_mask  (w_credit_ok),
    .o_grant (w_grant),
    .o_gid   (w_gid),
    .o_any   (w_any)
  );

  assign req_rdy = w_grant;

  // Issue stage: operands are captured on a grant and held otherwise. The
  // issue tag travels with fpu_arg_vld and feeds the tag pipeline, so the
  // last stage lines up with the cycle the adder raises fpu_res_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpu_a <= '0;
      r_fpu_b <= '0;
      r_issue <= '0;
    end else begin
      r_issue.valid <= w_any;
      r_issue.id    <= w_gid;
      if (w_any) begin
        r_fpu_a <= w_a[w_gid];
        r_fpu_b <= w_b[w_gid];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= r_issue;
      for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out  = r_tag[LATENCY-1];
  assign w_rsp_take = w_tag_out.valid & fpu_res_vld;

  // A result without a tag, or a tag without a result, is dropped and
  // flagged; only the matched case produces a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld    <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_state  <= OK;
      r_err        <= 1'b0;
    end else begin
      r_rsp_vld <= w_rsp_take;
      if (w_rsp_take) begin
        r_rsp_id     <= w_tag_out.id;
        r_rsp_result <= fpu_result;
        r_rsp_state  <= fpu_state_t'(fpu_state);
      end
      r_err <= r_err | (w_tag_out.valid ^ fpu_res_vld);
    end
  end

  // Grant and return for the same requester in one cycle cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_grant[i]) - CNT_W'(w_ret[i]);
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < N_REQ; i++) w_busy = w_busy | (r_cnt[i] != '0);
  end

  assign fpu_a       = r_fpu_a;
  assign fpu_b       = r_fpu_b;
  assign fpu_arg_vld = r_issue.valid;
  assign rsp_vld     = r_rsp_vld;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_state   = r_rsp_state;
  assign busy        = w_busy;
  assign err_sync    = r_err;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_add_arbiter
// Drives the arbiter with directed and random request patterns, models the
// shared adder, and compares every cycle against a transaction-level model:
// each granted operation is a record {grant cycle, id, a, b}; credits,
// busy, issue and response timing are derived from those records.
// ---------------------------------------------------------------------------
module tb_fpu_add_arbiter;
  import fpu_pkg::*;

  localparam int N_REQ   = 4;
  localparam int LATENCY = 6;
  localparam int MAX_OUT = 2;
  localparam int ID_W    = 2;
  localparam int RSP_LAT = LATENCY + 2;
  localparam int SCH     = 64;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [N_REQ-1:0]  req_vld;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ-1:0]  req_rdy;
  logic [31:0]       fpu_a;
  logic [31:0]       fpu_b;
  logic              fpu_arg_vld;
  logic [31:0]       fpu_result;
  logic [1:0]        fpu_state;
  logic              fpu_res_vld;
  logic              rsp_vld;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       rsp_result;
  logic [1:0]        rsp_state;
  logic              busy;
  logic              err_sync;

  always #5 clk = ~clk;

  fpu_add_arbiter #(
    .N_REQ   (N_REQ),
    .LATENCY (LATENCY),
    .MAX_OUT (MAX_OUT),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rdy     (req_rdy),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_arg_vld (fpu_arg_vld),
    .fpu_result  (fpu_result),
    .fpu_state   (fpu_state),
    .fpu_res_vld (fpu_res_vld),
    .rsp_vld     (rsp_vld),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_state   (rsp_state),
    .busy        (busy),
    .err_sync    (err_sync)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          rr_ptr   = 0;
  logic        err_exp  = 1'b0;
  logic        chk_rst_vals = 1'b0;
  logic        prev_any = 1'b0;
  logic [31:0] prev_a   = '0;
  logic [31:0] prev_b   = '0;
  logic        inject   = 1'b0;

  // adder model: results scheduled by the cycle they must appear in
  logic        sch_vld [SCH];
  logic [31:0] sch_res [SCH];
  logic [1:0]  sch_st  [SCH];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] add_model(logic [31:0] a, logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b;
  endfunction

  // The low two bits of operand b choose the status the model adder reports.
  function automatic logic [1:0] state_model(logic [31:0] b);
    return b[1:0];
  endfunction

  // An operation holds its requester's credit from the cycle after its
  // grant until the cycle its response appears.
  function automatic int credits_in_use(int id, int c);
    int n = 0;
    foreach (exp_q[k])
      if (exp_q[k].id == id && exp_q[k].cyc < c && c < exp_q[k].cyc + RSP_LAT) n++;
    return n;
  endfunction

  task automatic model_check();
    logic [N_REQ-1:0] exp_gnt = '0;
    int   gid = -1;
    logic busy_exp = 1'b0;
    logic rv_exp = 1'b0;
    op_t  rop;
    rop = '{0, 0, 32'h0, 32'h0};
    for (int k = 0; k < N_REQ; k++) begin
      int i = (rr_ptr + k) % N_REQ;
      if (gid < 0 && req_vld[i] && credits_in_use(i, cyc) < MAX_OUT) begin
        gid = i;
        exp_gnt[i] = 1'b1;
      end
    end
    check("req_rdy", 32'(req_rdy), 32'(exp_gnt));
    check("fpu_arg_vld", 32'(fpu_arg_vld), 32'(prev_any));
    if (prev_any) begin
      check("fpu_a", fpu_a, prev_a);
      check("fpu_b", fpu_b, prev_b);
    end
    foreach (exp_q[k]) begin
      if (exp_q[k].cyc + RSP_LAT == cyc) begin
        rv_exp = 1'b1;
        rop = exp_q[k];
      end
      if (exp_q[k].cyc < cyc && cyc < exp_q[k].cyc + RSP_LAT) busy_exp = 1'b1;
    end
    check("rsp_vld", 32'(rsp_vld), 32'(rv_exp));
    if (rv_exp) begin
      check("rsp_id", 32'(rsp_id), 32'(rop.id));
      check("rsp_result", rsp_result, add_model(rop.a, rop.b));
      check("rsp_state", 32'(rsp_state), 32'(state_model(rop.b)));
    end
    check("busy", 32'(busy), 32'(busy_exp));
    check("err_sync", 32'(err_sync), 32'(err_exp));
    if (chk_rst_vals) begin
      check("rst_fpu_a", fpu_a, 32'h0);
      check("rst_fpu_b", fpu_b, 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_result", rsp_result, 32'h0);
      check("rst_rsp_state", 32'(rsp_state), 32'(OK));
      chk_rst_vals = 1'b0;
    end
    prev_any = (gid >= 0);
    if (gid >= 0) begin
      prev_a = req_a[gid*32 +: 32];
      prev_b = req_b[gid*32 +: 32];
      exp_q.push_back('{cyc, gid, prev_a, prev_b});
      rr_ptr = (gid + 1) % N_REQ;
    end
    while (exp_q.size() > 0 && exp_q[0].cyc + RSP_LAT < cyc) void'(exp_q.pop_front());
  endtask

  // One clock cycle: check at the falling edge, then advance and drive the
  // adder outputs for the new cycle just after the rising edge.
  task automatic run_cycle();
    logic tag_exp;
    int   idx;
    @(negedge clk);
    if (!rst) begin
      model_check();
      if (fpu_arg_vld) begin
        idx = (cyc + LATENCY) % SCH;
        sch_vld[idx] = 1'b1;
        sch_res[idx] = add_model(fpu_a, fpu_b);
        sch_st[idx]  = state_model(fpu_b);
      end
      tag_exp = 1'b0;
      foreach (exp_q[k]) if (exp_q[k].cyc + LATENCY + 1 == cyc) tag_exp = 1'b1;
      if (fpu_res_vld != tag_exp) err_exp = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      rr_ptr   = 0;
      err_exp  = 1'b0;
      prev_any = 1'b0;
      for (int k = 0; k < SCH; k++) sch_vld[k] = 1'b0;
    end
    idx = cyc % SCH;
    fpu_res_vld = sch_vld[idx] | inject;
    fpu_result  = inject ? 32'hDEADBEEF : sch_res[idx];
    fpu_state   = inject ? 2'b11 : sch_st[idx];
    sch_vld[idx] = 1'b0;
    inject = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(int n);
    repeat (n) run_cycle();
  endtask

  task automatic set_ops(int i, logic [31:0] a, logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) set_ops(i, $urandom(), $urandom());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_vld = '0;
    req_a = '0;
    req_b = '0;
    fpu_res_vld = 1'b0;
    fpu_result = '0;
    fpu_state = '0;
    for (int k = 0; k < SCH; k++) begin
      sch_vld[k] = 1'b0;
      sch_res[k] = '0;
      sch_st[k]  = '0;
    end
    idle(2);
    rst = 1'b0;
    chk_rst_vals = 1'b1;

    // single request from requester 0
    req_vld = 4'b0001;
    set_ops(0, 32'h3F800000, 32'h40000000);
    run_cycle();
    req_vld = '0;
    idle(12);

    // all requesters held valid: rotation and sustained issue
    req_vld = 4'b1111;
    repeat (24) begin rand_ops(); run_cycle(); end
    req_vld = '0;
    idle(12);

    // requester 2 alone runs into its credit limit
    req_vld = 4'b0100;
    repeat (20) begin rand_ops(); run_cycle(); end
    req_vld = '0;
    idle(12);

    // NAN status returned for requester 1
    req_vld = 4'b0010;
    set_ops(1, 32'h7FC00000, 32'h3F800001);
    run_cycle();
    req_vld = '0;
    idle(12);

    // random traffic
    repeat (300) begin
      req_vld = 4'($urandom_range(0, 15));
      rand_ops();
      run_cycle();
    end
    req_vld = '0;
    idle(12);

    // adder result with no tag in flight, then a normal operation
    inject = 1'b1;
    idle(3);
    req_vld = 4'b1000;
    rand_ops();
    run_cycle();
    req_vld = '0;
    idle(12);

    // reset while three operations are in flight
    req_vld = 4'b1111;
    repeat (3) begin rand_ops(); run_cycle(); end
    req_vld = '0;
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    chk_rst_vals = 1'b1;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one pipelined floating_point_adder instance among N_REQ requesters.
- Round-robin arbitration with per-requester outstanding-credit limits.
- A tag pipeline aligned to the adder latency routes each result back to its requester.
- Sits between the FPU client ports and the adder; it performs no arithmetic.

Parameters:
- N_REQ, 4, number of requesters.
- LATENCY, 6, adder cycles from fpu_arg_vld to fpu_res_vld.
- MAX_OUT, 2, maximum in-flight operations per requester.
- ID_W, $clog2(N_REQ), requester id width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_vld  in  N_REQ  per-requester operation request.
- req_a  in  N_REQ x 32  operand a per requester.
- req_b  in  N_REQ x 32  operand b per requester.
- req_rdy  out  N_REQ  grant; a transfer occurs when req_vld[i] & req_rdy[i].
- fpu_a  out  32  operand a to adder.
- fpu_b  out  32  operand b to adder.
- fpu_arg_vld  out  1  issue strobe to adder.
- fpu_result  in  32  adder result.
- fpu_state  in  2  adder status code.
- fpu_res_vld  in  1  adder result valid.
- rsp_vld  out  1  response valid.
- rsp_id  out  ID_W  requester owning the response.
- rsp_result  out  32  result, registered copy of fpu_result.
- rsp_state  out  2  status, registered copy of fpu_state.
- busy  out  1  any operation in flight.
- err_sync  out  1  sticky tag/result misalignment flag.

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. On rst:
  - rr pointer = 0; tag pipeline valids = 0; all credit counters = 0.
  - fpu_arg_vld = 0, fpu_a = fpu_b = 0.
  - rsp_vld = 0, rsp_id = 0, rsp_result = 0, rsp_state = OK.
  - busy = 0, err_sync = 0.
  - The adder shares rst, so both pipelines empty together; reset mid-operation discards all in-flight ops with no responses.
- Eligibility: eligible[i] = req_vld[i] & (cnt[i] < MAX_OUT).
- Grant: combinational, one-hot or zero. Search starts at rr pointer, wrapping modulo N_REQ; req_rdy[i] is asserted only for the first eligible requester. No grant when none is eligible.
- Issue: on a grant to i at cycle t, register fpu_a = req_a[i], fpu_b = req_b[i], fpu_arg_vld = 1 at t+1. Otherwise fpu_arg_vld = 0 and the operands hold their values.
- Pointer update: rr pointer = (i+1) mod N_REQ after a grant; unchanged without a grant.
- Tag pipeline: LATENCY-stage shift register of {valid, id}. It is loaded alongside fpu_arg_vld, so the tag emerges in the cycle fpu_res_vld is expected.
- Response:
  - When the tag stage is valid and fpu_res_vld = 1, register rsp_vld = 1 with rsp_id = tag id, rsp_result and rsp_state one cycle later.
  - Total request-to-response latency is LATENCY+2 cycles.
  - There is no response backpressure; requesters must always accept.
- Credits:
  - cnt[i] increments on grant to i and decrements when a response for i is produced.
  - Grant and response for the same i in one cycle leave cnt unchanged.
  - cnt never exceeds MAX_OUT or goes below 0.
- Misalignment: fpu_res_vld xor tag-stage valid sets err_sync (sticky until rst).
  - Tag-only case: the op is dropped and its credit is returned.
  - fpu_res_vld-only case: the result is dropped.
- busy = OR of all cnt[i] != 0.
- Throughput: one issue per cycle sustained when requesters have credit.

Decomposition:
- Shared package fpu_pkg holds:
  - fpu_state_t enum: OK=2'b00, NAN=2'b01, INF=2'b10, NUL=2'b11.
  - fpu_tag_t struct {valid, id}.
  - FP32 field-width constants.
- One sub-module: rr_arbiter (N_REQ-wide round-robin priority picker with pointer register and mask input).
- The tag pipeline is inline.

Test Plan:
- Single request: req 0 sends a=0x3F800000, b=0x40000000; a model adder returns 0x40400000 at LATENCY. Expect rsp_vld with rsp_id=0, rsp_result=0x40400000, rsp_state=OK, 8 cycles after the grant cycle.
- Round-robin: all four requesters hold req_vld continuously. Expect grant order 0,1,2,3,0,… and one fpu_arg_vld per cycle. Each rsp_id must match its issue order.
- Credit limit: requester 2 alone, MAX_OUT=2, held valid. Expect grants at t and t+1, then req_rdy[2]=0 until its first response, then a grant resumes the same cycle its counter drops.
- Status passthrough: fpu_state=NAN returned for requester 1's op. Expect rsp_state=2'b01 and rsp_id=1.
- Misalignment: inject fpu_res_vld with no tag valid. Expect err_sync=1, no rsp_vld, and all credits unchanged.
- Reset mid-flight: assert rst with 3 ops in flight. Expect every output at its reset value the next cycle, busy=0, and no responses afterwards.
